// File: rtl/sddac_pkg.sv
// Shared constants and width helpers for the multi-channel sigma-delta DAC.
package sddac_pkg;

   localparam logic MODE_O1 = 1'b0;
   localparam logic MODE_O2 = 1'b1;

   localparam int unsigned DEFAULT_OSR = 1000;

   // First integrator needs two guard bits, second needs four.
   function automatic int unsigned i1_width(input int unsigned in_w);
      return in_w + 32'd2;
   endfunction

   function automatic int unsigned i2_width(input int unsigned in_w);
      return in_w + 32'd4;
   endfunction

endpackage

// File: rtl/sddac_multi_if.sv
// Parallel PCM frame handshake between the sample source and the DAC.
interface sddac_multi_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned IN_W     = 16
);
   logic                     s_valid;
   logic                     s_ready;
   logic [CHANNELS*IN_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sddac_chan.sv
// One modulator channel: active sample, mode latch, first/second-order loops.
module sddac_chan
   import sddac_pkg::*;
#(
   parameter int unsigned IN_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            load,
   input  logic            order_sel,
   input  logic [IN_W-1:0] load_data,
   output logic            sd_out
);

   localparam int unsigned W1 = i1_width(IN_W);
   localparam int unsigned W2 = i2_width(IN_W);
   localparam int unsigned WS = W2 + 2;

   localparam logic signed [WS-1:0] FS_P   = $signed({{(WS-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}});
   localparam logic signed [WS-1:0] I1_MAX = $signed({{(WS-W1+1){1'b0}}, {(W1-1){1'b1}}});
   localparam logic signed [WS-1:0] I1_MIN = ~I1_MAX;
   localparam logic signed [WS-1:0] I2_MAX = $signed({{(WS-W2+1){1'b0}}, {(W2-1){1'b1}}});
   localparam logic signed [WS-1:0] I2_MIN = ~I2_MAX;

   logic                   mode;
   logic [IN_W-1:0]        active;
   logic [IN_W:0]          acc;
   logic signed [W1-1:0]   i1;
   logic signed [W2-1:0]   i2;

   logic signed [IN_W-1:0] x;
   logic [IN_W:0]          acc_nxt;
   logic signed [WS-1:0]   fb;
   logic signed [WS-1:0]   s1;
   logic signed [WS-1:0]   s2;
   logic signed [W1-1:0]   i1_nxt;
   logic signed [W2-1:0]   i2_nxt;
   logic                   mode_chg;

   // The sample arriving at a tick drives the loop in that same cycle.
   always_comb begin
      x        = load ? load_data : active;
      acc_nxt  = {1'b0, acc[IN_W-1:0]} + {1'b0, ~x[IN_W-1], x[IN_W-2:0]};
      fb       = sd_out ? FS_P : -FS_P;
      s1       = WS'(i1) + WS'(x) - fb;
      i1_nxt   = (s1 > I1_MAX) ? I1_MAX[W1-1:0] :
                 (s1 < I1_MIN) ? I1_MIN[W1-1:0] : s1[W1-1:0];
      s2       = WS'(i2) + WS'(i1_nxt) - fb;
      i2_nxt   = (s2 > I2_MAX) ? I2_MAX[W2-1:0] :
                 (s2 < I2_MIN) ? I2_MIN[W2-1:0] : s2[W2-1:0];
      mode_chg = tick & (order_sel != mode);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode   <= MODE_O1;
         active <= '0;
         acc    <= '0;
         i1     <= '0;
         i2     <= '0;
         sd_out <= 1'b0;
      end else begin
         if (load) active <= load_data;
         if (mode_chg) begin
            mode   <= order_sel;
            acc    <= '0;
            i1     <= '0;
            i2     <= '0;
            sd_out <= 1'b0;
         end else if (mode == MODE_O2) begin
            i1     <= i1_nxt;
            i2     <= i2_nxt;
            sd_out <= ~i2_nxt[W2-1];
         end else begin
            acc    <= acc_nxt;
            sd_out <= acc_nxt[IN_W];
         end
      end
   end

endmodule

// File: rtl/sddac_multi.sv
// Multi-channel sigma-delta DAC front end: rate divider, pending frame slot, channels.
module sddac_multi
   import sddac_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned IN_W     = 16,
   parameter int unsigned OSR      = DEFAULT_OSR
) (
   input  logic                clk,
   input  logic                rst,
   sddac_multi_if.slave        s,
   input  logic                order_sel,
   input  logic                mute,
   output logic [CHANNELS-1:0] sd_out,
   output logic                tick,
   output logic                underrun
);

   localparam int unsigned     CW   = $clog2(OSR);
   localparam logic [CW-1:0]   LAST = CW'(OSR - 1);

   logic [CW-1:0]            cnt;
   logic [CW-1:0]            cnt_nxt;
   logic                     full;
   logic                     full_nxt;
   logic                     ready_q;
   logic                     accept;
   logic                     load;
   logic                     tick_nxt;
   logic [CHANNELS*IN_W-1:0] pend;

   assign s.s_ready = ready_q;

   // Muted ticks keep the pending frame; only an unmuted tick consumes it.
   always_comb begin
      accept   = s.s_valid & ready_q;
      cnt_nxt  = (cnt == LAST) ? '0 : cnt + CW'(1);
      tick_nxt = (cnt_nxt == LAST);
      full_nxt = full;
      if (accept)
         full_nxt = 1'b1;
      else if (tick & ~mute)
         full_nxt = 1'b0;
      load     = tick & (full | mute);
   end

   // tick, underrun and s_ready are registered copies of their next-cycle decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         full     <= 1'b0;
         pend     <= '0;
         tick     <= 1'b0;
         underrun <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         cnt      <= cnt_nxt;
         full     <= full_nxt;
         if (accept) pend <= s.s_data;
         tick     <= tick_nxt;
         underrun <= tick_nxt & ~full_nxt;
         ready_q  <= ~full_nxt | tick_nxt;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      sddac_chan #(.IN_W(IN_W)) u_chan (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick),
         .load      (load),
         .order_sel (order_sel),
         .load_data (mute ? '0 : pend[c*IN_W +: IN_W]),
         .sd_out    (sd_out[c])
      );
   end

endmodule

// File: tb/tb_sddac_multi.sv
// Scoreboard bench for sddac_multi: behavioural model predicts every output cycle.
module tb_sddac_multi;

   localparam int     CH  = 2;
   localparam int     W   = 16;
   localparam int     OSR = 16;
   localparam longint FS  = longint'(1) << (W - 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          order_sel = 1'b0;
   logic          mute = 1'b0;
   logic [CH-1:0] sd_out;
   logic          tick;
   logic          underrun;

   sddac_multi_if #(.CHANNELS(CH), .IN_W(W)) bus ();

   sddac_multi #(.CHANNELS(CH), .IN_W(W), .OSR(OSR)) dut (
      .clk       (clk),
      .rst       (rst),
      .s         (bus),
      .order_sel (order_sel),
      .mute      (mute),
      .sd_out    (sd_out),
      .tick      (tick),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          ready;
      logic          tck;
      logic          und;
      logic [CH-1:0] sd;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input longint got, input longint want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, want);
      end
   endtask

   // Reference model: frame queue of depth one, integer integrators.
   int     m_cnt;
   bit     m_full;
   longint m_pend[CH];
   longint m_act[CH];
   longint m_acc[CH];
   longint m_i1[CH];
   longint m_i2[CH];
   bit     m_mode[CH];
   bit     m_sd[CH];

   function automatic longint sat(input longint v, input int bits);
      longint lim = longint'(1) << (bits - 1);
      if (v > lim - 1) return lim - 1;
      if (v < -lim)    return -lim;
      return v;
   endfunction

   function automatic exp_t cur_exp();
      exp_t e;
      e.tck   = (m_cnt == OSR - 1);
      e.ready = !m_full || e.tck;
      e.und   = e.tck && !m_full;
      for (int c = 0; c < CH; c++) e.sd[c] = m_sd[c];
      return e;
   endfunction

   task automatic model_reset();
      m_cnt  = 0;
      m_full = 0;
      for (int c = 0; c < CH; c++) begin
         m_pend[c] = 0; m_act[c] = 0; m_acc[c] = 0;
         m_i1[c] = 0; m_i2[c] = 0; m_mode[c] = 0; m_sd[c] = 0;
      end
   endtask

   task automatic model_step();
      bit tk     = (m_cnt == OSR - 1);
      bit rdy    = !m_full || tk;
      bit acc_ok = bus.s_valid && rdy;
      for (int c = 0; c < CH; c++) begin
         longint x  = m_act[c];
         bit     ld = tk && (m_full || mute);
         longint nv = mute ? 0 : m_pend[c];
         longint fb;
         if (ld) x = nv;
         if (tk && (order_sel != m_mode[c])) begin
            m_mode[c] = order_sel;
            m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_sd[c] = 0;
         end else if (!m_mode[c]) begin
            m_acc[c] = (m_acc[c] % (longint'(1) << W)) + x + FS;
            m_sd[c]  = (m_acc[c] >= (longint'(1) << W));
         end else begin
            fb      = m_sd[c] ? FS : -FS;
            m_i1[c] = sat(m_i1[c] + x - fb, W + 2);
            m_i2[c] = sat(m_i2[c] + m_i1[c] - fb, W + 4);
            m_sd[c] = (m_i2[c] >= 0);
         end
         if (ld) m_act[c] = nv;
      end
      if (acc_ok) begin
         for (int c = 0; c < CH; c++) m_pend[c] = longint'($signed(bus.s_data[c*W +: W]));
         m_full = 1;
      end else if (tk && !mute) begin
         m_full = 0;
      end
      m_cnt = (m_cnt == OSR - 1) ? 0 : m_cnt + 1;
   endtask

   // Predictor: pushes the expected outputs for the cycle that follows each edge.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            model_reset();
            q.delete();
            q.push_back(cur_exp());
         end else begin
            model_step();
            q.push_back(cur_exp());
         end
      end
   end

   // Monitor: compares DUT outputs against the queue away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = q.pop_front();
         chk("s_ready",  longint'(bus.s_ready), longint'(e.ready));
         chk("tick",     longint'(tick),        longint'(e.tck));
         chk("underrun", longint'(underrun),    longint'(e.und));
         chk("sd_out",   longint'(sd_out),      longint'(e.sd));
      end
   end

   task automatic set_frame(input int x0, input int x1);
      bus.s_data[0 +: W] = W'(x0);
      bus.s_data[W +: W] = W'(x1);
   endtask

   task automatic hold(input int x0, input int x1, input int n);
      bus.s_valid = 1'b1;
      set_frame(x0, x1);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_ones(input int n, output int o0, output int o1);
      o0 = 0; o1 = 0;
      repeat (n) begin
         @(negedge clk);
         o0 += int'(sd_out[0]);
         o1 += int'(sd_out[1]);
      end
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(58982)) - 29491;
   endfunction

   task automatic random_phase(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.s_valid = ($urandom_range(3) != 0);
         set_frame(rnd_sample(), rnd_sample());
         mute = ($urandom_range(31) == 0);
         if ($urandom_range(199) == 0) order_sel = ~order_sel;
      end
      mute = 1'b0;
   endtask

   initial begin
      int o0, o1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;

      // First-order densities
      hold(-32768, 16384, 4 * OSR);
      count_ones(64, o0, o1);
      chk("o1_neg_fullscale_ones", o0, 0);
      chk("o1_half_pos_ones", o1, 48);
      hold(0, -16384, 4 * OSR);
      count_ones(64, o0, o1);
      chk("o1_zero_ones", o0, 32);
      chk("o1_half_neg_ones", o1, 16);

      // Second-order steady drive, then randomized traffic with mode switches
      order_sel = 1'b1;
      hold(16384, -20000, 20 * OSR);
      random_phase(600);

      // Underrun: source stalls
      bus.s_valid = 1'b0;
      repeat (4 * OSR) @(negedge clk);

      // Mute with a pending frame
      hold(12000, -7000, 1);
      bus.s_valid = 1'b0;
      mute = 1'b1;
      repeat (3 * OSR) @(negedge clk);
      mute = 1'b0;
      repeat (3 * OSR) @(negedge clk);

      // Mid-stream asynchronous reset
      hold(3000, -3000, 5 * OSR + 7);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_sd_out",   longint'(sd_out),      0);
      chk("rst_tick",     longint'(tick),        0);
      chk("rst_underrun", longint'(underrun),    0);
      chk("rst_s_ready",  longint'(bus.s_ready), 1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;

      random_phase(400);
      bus.s_valid = 1'b0;
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sddac_multi.md
# sddac_multi

Multi-channel, parametrised sigma-delta audio DAC front end. Accepts interleaved-free parallel PCM frames over a valid/ready handshake and paces them with an internal sample-rate divider. Each channel runs a runtime-selectable first- or second-order 1-bit modulator. It replaces the single-channel fixed-width sddac between the sample source (rom_wavegen or the audio path) and the PDM output pins.

## Interface
- CHANNELS, 2, number of independent modulator channels
- IN_W, 16, signed two's-complement sample width per channel
- OSR, 1000, clk cycles per sample period (1000 gives 48 kHz at 48 MHz); minimum 4
- clk  in  1  modulator and system clock
- rst  in  1  reset, asynchronous, active-low
- s_valid  in  1  frame valid
- s_ready  out  1  frame slot available
- s_data  in  CHANNELS*IN_W  frame; channel c in bits [c*IN_W +: IN_W]
- order_sel  in  1  0 = first-order, 1 = second-order; sampled at tick
- mute  in  1  force zero input from next tick
- sd_out  out  CHANNELS  registered 1-bit PDM outputs
- tick  out  1  one-cycle pulse, last cycle of each sample period
- underrun  out  1  one-cycle pulse: tick with no pending frame

## Operation
- Divider: cnt counts 0..OSR-1 and wraps. tick = (cnt == OSR-1).
- Pending slot: one frame register plus a full flag.
  - s_ready = ~full | tick.
  - Accept on s_valid & s_ready: the frame is written to the slot and full is set.
- At tick:
  - If full, the pending frame moves to the active register.
  - If not full, the active register holds its value and underrun pulses.
  - Accept and tick in the same cycle: the slot is loaded with the new frame, full stays 1, and the old pending frame becomes active. A frame is never bypassed to active in its accept cycle.
- Mute: when mute is high at tick, the active register loads zero. The pending frame is retained and not consumed.
- order_sel is latched at tick. A change of mode clears that channel's integrators in the same tick.
- First-order (per channel):
  - u = x with MSB inverted (offset binary, IN_W bits).
  - acc (IN_W+1 bits) <= acc[IN_W-1:0] + u.
  - sd_out <= acc_next[IN_W].
  - Ones density = u / 2^IN_W.
- Second-order (per channel):
  - FS = 2^(IN_W-1).
  - fb = +FS when sd_out = 1, otherwise -FS.
  - i1 (IN_W+2 bits) <= i1 + x - fb.
  - i2 (IN_W+4 bits) <= i2 + i1_next - fb.
  - sd_out <= ~i2_next[MSB], i.e. 1 when i2_next >= 0.
  - i1 and i2 saturate at their signed limits; they never wrap.
- Full-scale negative input (-2^(IN_W-1)) gives constant 0 in first-order. Maximum positive input gives density (2^IN_W - 1)/2^IN_W.

## Timing
- Reset values: s_ready = 1, sd_out = 0, tick = 0, underrun = 0. Also cnt = 0, full = 0, active = 0, acc/i1/i2 = 0, latched order = 0.
- Latency:
  - A frame accepted in cycle t becomes active at the first tick strictly after t.
  - sd_out reflects the new active value from the cycle after that tick.
- Modulators update every clk cycle; sd_out changes only on clk rising edge.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first tick after release occurs OSR cycles later.
- Back-pressure: while full and not tick, s_ready = 0 and s_data is ignored.

## Structure
- Package sddac_pkg:
  - mode constants MODE_O1 = 0, MODE_O2 = 1;
  - width helpers IN_W+2 and IN_W+4;
  - default OSR.
- Sub-module sddac_chan: one channel holding the active sample, mode latch, both integrator sets and the output register. It is generated CHANNELS times.
- The top level holds the divider, pending slot, handshake, and mute/underrun logic.

## Test plan
- **Reset:** rst low mid-stream with IN_W=16, OSR=16 -> all outputs 0 and s_ready = 1 immediately; first tick 16 cycles after release.
- **First-order density:** x = 0 -> sd_out alternates 0/1. x = +16384 -> exactly 48 ones in any 64-cycle window. x = -32768 -> constant 0.
- **Second-order density:** x = +16384 -> ones count 3072 ± 2 over 4096 cycles after 64-cycle settling. Integrators do not saturate for |x| ≤ 0.9 FS.
- **Handshake:** s_valid held high with OSR=16 -> one accept per tick, s_ready high only on tick cycles after the first fill. Frames become active in order with no drop or duplicate.
- **Underrun and mute:**
  - Stop s_valid -> underrun pulses on each tick and the last value is held.
  - mute = 1 -> active = 0 from the next tick and the pending frame stays full.
- **Mode switch and channel independence:** change order_sel mid-period -> integrators clear at the tick and density is correct after settling. With CHANNELS = 2 and different x per channel, each output density matches its own input.
